// File: rtl/fpu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_pkg
//  Purpose  : Shared types and constants for the FPU issue front end.
//             Holds the opcode encoding, the response-credit depth, the FPU
//             pipeline latency, the result flag bit positions and the
//             result classification helper.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_issue_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_PASS = 3'b100,
        OP_NOP  = 3'b111
    } fpu_op_e;

    // Response queue depth; it is also the number of issue credits.
    localparam int RSP_DEPTH = 4;
    // Cycles from operands leaving this block to the FPU result register.
    localparam int FPU_LAT   = 2;

    // Bit positions inside rsp_flags.
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_ILL  = 0;

    // Classify a single-precision result and mark opcodes outside the
    // defined set. Denormals are deliberately not reported as zero.
    function automatic logic [3:0] classify(input logic [31:0] res,
                                            input logic [2:0]  op);
        logic [7:0]  exp_f;
        logic [22:0] man_f;
        logic [3:0]  flags;
        exp_f = res[30:23];
        man_f = res[22:0];
        flags = 4'b0000;
        flags[FLAG_NAN]  = (exp_f == 8'hFF) && (man_f != 23'd0);
        flags[FLAG_INF]  = (exp_f == 8'hFF) && (man_f == 23'd0);
        flags[FLAG_ZERO] = (exp_f == 8'h00) && (man_f == 23'd0);
        flags[FLAG_ILL]  = (op > OP_PASS);
        return flags;
    endfunction

endpackage : fpu_issue_pkg
`default_nettype wire

// File: rtl/fpu_issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_fifo
//  Purpose  : Synchronous FIFO, first-word-fall-through read port.
//             Pointers are log2(DEPTH) bits and wrap naturally; full/empty
//             are derived from a separate occupancy counter.
//  Ports    : clk, rst        clock, synchronous active-high reset
//             push, din       write strobe and data
//             pop, dout       read strobe and head data
//             full, empty     occupancy status
//             count           number of stored entries
//  Revision : 1.0  initial release
// ============================================================================
module fpu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // A pop frees a slot on the same edge, so a full FIFO still takes a push
    // that coincides with a pop.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : fpu_issue_fifo
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_ctrl
//  Purpose  : Request-side front end for the single-precision FPU. Queues
//             tagged requests, issues one per cycle into the handshake-less
//             FPU, tracks them through a 2-stage shadow pipe and returns the
//             results in order with their tags.
//  Config   : FPU_ISSUE_FLAGS_EN - when defined, per-entry result flags
//             {nan, inf, zero, illegal_op} are produced; otherwise rsp_flags
//             is tied to zero and no flag logic is built.
//  Ports    : clk, rst                     clock, sync active-high reset
//             req_valid/ready, req_a/b,
//             req_op, req_tag              request handshake and payload
//             fpu_a/b, fpu_opcode          registered FPU inputs
//             fpu_result                   registered FPU output
//             rsp_valid/ready, rsp_result,
//             rsp_tag, rsp_flags           response handshake and payload
//  Revision : 1.0  initial release
// ============================================================================
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [2:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [31:0]       fpu_a,
    output logic [31:0]       fpu_b,
    output logic [2:0]        fpu_opcode,
    input  logic [31:0]       fpu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [3:0]        rsp_flags
);

    localparam int c_REQ_W     = 32 + 32 + 3 + TAG_W;
`ifdef FPU_ISSUE_FLAGS_EN
    localparam int c_RSP_W     = 32 + TAG_W + 4;
`else
    localparam int c_RSP_W     = 32 + TAG_W;
`endif
    localparam int c_REQ_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_RSP_CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int c_CREDIT_W  = $clog2(RSP_DEPTH + FPU_LAT) + 1;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    logic                   w_req_push;
    logic [c_REQ_W-1:0]     w_req_din;
    logic [c_REQ_W-1:0]     w_req_dout;
    logic                   w_req_full;
    logic                   w_req_empty;
    logic [c_REQ_CNT_W-1:0] w_req_count;
    logic                   w_issue;

    logic [31:0]            w_head_a;
    logic [31:0]            w_head_b;
    logic [2:0]             w_head_op;
    logic [TAG_W-1:0]       w_head_tag;

    assign req_ready  = !w_req_full;
    assign w_req_push = req_valid && req_ready;
    assign w_req_din  = {req_a, req_b, req_op, req_tag};

    fpu_issue_fifo #(
        .WIDTH (c_REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_req_push),
        .din   (w_req_din),
        .pop   (w_issue),
        .dout  (w_req_dout),
        .full  (w_req_full),
        .empty (w_req_empty),
        .count (w_req_count)
    );

    assign w_head_a   = w_req_dout[c_REQ_W-1 -: 32];
    assign w_head_b   = w_req_dout[c_REQ_W-33 -: 32];
    assign w_head_op  = w_req_dout[TAG_W +: 3];
    assign w_head_tag = w_req_dout[TAG_W-1:0];

    // ------------------------------------------------------------------
    // Credit-based issue. Every op in the shadow pipe or waiting in the
    // response queue holds one credit, so a result arriving from the FPU
    // always finds a free response slot even with rsp_ready held low.
    // ------------------------------------------------------------------
    logic                   r_s1_valid;
    logic [TAG_W-1:0]       r_s1_tag;
    logic                   r_s2_valid;
    logic [TAG_W-1:0]       r_s2_tag;
`ifdef FPU_ISSUE_FLAGS_EN
    logic [2:0]             r_s1_op;
    logic [2:0]             r_s2_op;
`endif

    logic [31:0]            r_fpu_a;
    logic [31:0]            r_fpu_b;
    logic [2:0]             r_fpu_opcode;

    logic                   w_rsp_push;
    logic                   w_rsp_pop;
    logic [c_RSP_W-1:0]     w_rsp_din;
    logic [c_RSP_W-1:0]     w_rsp_dout;
    logic                   w_rsp_full;
    logic                   w_rsp_empty;
    logic [c_RSP_CNT_W-1:0] w_rsp_count;
    logic [c_CREDIT_W-1:0]  w_credit_used;

    assign w_credit_used = c_CREDIT_W'(r_s1_valid) + c_CREDIT_W'(r_s2_valid)
                         + c_CREDIT_W'(w_rsp_count);
    assign w_issue = !w_req_empty
                  && (w_credit_used < c_CREDIT_W'(RSP_DEPTH))
                  && !w_rsp_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_opcode <= OP_NOP;
            r_s1_valid   <= 1'b0;
            r_s1_tag     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_tag     <= '0;
`ifdef FPU_ISSUE_FLAGS_EN
            r_s1_op      <= OP_NOP;
            r_s2_op      <= OP_NOP;
`endif
        end else begin
            // Operands hold when idle; only the opcode returns to NOP.
            if (w_issue) begin
                r_fpu_a      <= w_head_a;
                r_fpu_b      <= w_head_b;
                r_fpu_opcode <= w_head_op;
            end else begin
                r_fpu_opcode <= OP_NOP;
            end
            r_s1_valid <= w_issue;
            r_s1_tag   <= w_head_tag;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
`ifdef FPU_ISSUE_FLAGS_EN
            r_s1_op    <= w_head_op;
            r_s2_op    <= r_s1_op;
`endif
        end
    end

    assign fpu_a      = r_fpu_a;
    assign fpu_b      = r_fpu_b;
    assign fpu_opcode = r_fpu_opcode;

    // ------------------------------------------------------------------
    // Response queue. s2 lines up with the FPU result register.
    // ------------------------------------------------------------------
    assign w_rsp_push = r_s2_valid;
    assign w_rsp_pop  = rsp_valid && rsp_ready;

`ifdef FPU_ISSUE_FLAGS_EN
    assign w_rsp_din  = {fpu_result, r_s2_tag, classify(fpu_result, r_s2_op)};
`else
    assign w_rsp_din  = {fpu_result, r_s2_tag};
`endif

    fpu_issue_fifo #(
        .WIDTH (c_RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rsp_push),
        .din   (w_rsp_din),
        .pop   (w_rsp_pop),
        .dout  (w_rsp_dout),
        .full  (w_rsp_full),
        .empty (w_rsp_empty),
        .count (w_rsp_count)
    );

    // Payload is forced to zero while empty so unwritten storage never shows.
    assign rsp_valid  = !w_rsp_empty;
    assign rsp_result = rsp_valid ? w_rsp_dout[c_RSP_W-1 -: 32] : 32'd0;
`ifdef FPU_ISSUE_FLAGS_EN
    assign rsp_tag    = rsp_valid ? w_rsp_dout[4 +: TAG_W] : '0;
    assign rsp_flags  = rsp_valid ? w_rsp_dout[3:0] : 4'b0000;
`else
    assign rsp_tag    = rsp_valid ? w_rsp_dout[TAG_W-1:0] : '0;
    assign rsp_flags  = 4'b0000;
`endif

    // Invariants of the credit scheme; ignored by synthesis.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_rsp_push && w_rsp_full && !w_rsp_pop));
            assert (w_req_count <= c_REQ_CNT_W'(DEPTH));
        end
    end

endmodule : fpu_issue_ctrl
`default_nettype wire
